// File: rtl/rotary_position_counter.sv
// Purpose: accumulates quadrature step pulses into a bounded detent position.
// Latency: a step/load sampled on edge N is visible on position/changed after edge N.
// Backpressure: none; every pulse is consumed in the cycle it is presented.
//
// Ports:
//   clock       single system clock, rising edge
//   reset       synchronous, active-high; clears position, sub-step, dir and strobes
//   is_cw       one-cycle clockwise step pulse from the encoder
//   is_ccw      one-cycle counter-clockwise step pulse from the encoder
//   load        synchronous load strobe (beats any step input in the same cycle)
//   load_value  value to load, clamped to MAX_VALUE
//   position    registered detent position, 0..MAX_VALUE
//   changed     one-cycle pulse coincident with a new position value
//   dir         direction of the last accepted step (1 = cw, 0 = ccw)
//   at_min      position == 0
//   at_max      position == MAX_VALUE
//   conflict    one-cycle pulse after a cycle with both step inputs high

module rotary_position_counter #(
    parameter int WIDTH            = 8,
    parameter int STEPS_PER_DETENT = 4,
    parameter int MAX_VALUE        = 255,
    parameter int WRAP             = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             is_cw,
    input  logic             is_ccw,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] position,
    output logic             changed,
    output logic             dir,
    output logic             at_min,
    output logic             at_max,
    output logic             conflict
);

    // One extra bit over clog2 gives a signed range that covers +/-(S-1).
    localparam int SUB_W = $clog2(STEPS_PER_DETENT) + 1;

    localparam logic signed [SUB_W-1:0] SUB_TOP  = SUB_W'(STEPS_PER_DETENT - 1);
    localparam logic signed [SUB_W-1:0] SUB_BOT  = SUB_W'(-(STEPS_PER_DETENT - 1));
    localparam logic signed [SUB_W-1:0] SUB_ZERO = '0;
    localparam logic signed [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
    localparam logic [WIDTH-1:0]        POS_MAX  = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0]        POS_ONE  = WIDTH'(1);

    logic [WIDTH-1:0]        pos_q, pos_d;
    logic signed [SUB_W-1:0] sub_q, sub_d;
    logic                    dir_q, dir_d;
    logic                    changed_q, changed_d;
    logic                    conflict_q, conflict_d;
    logic                    inc_req;
    logic                    dec_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            pos_q      <= '0;
            sub_q      <= SUB_ZERO;
            dir_q      <= 1'b0;
            changed_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            sub_q      <= sub_d;
            dir_q      <= dir_d;
            changed_q  <= changed_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        pos_d      = pos_q;
        sub_d      = sub_q;
        dir_d      = dir_q;
        conflict_d = 1'b0;
        inc_req    = 1'b0;
        dec_req    = 1'b0;

        if (load) begin
            // Load discards any partial detent and ignores same-cycle steps.
            pos_d = (load_value > POS_MAX) ? POS_MAX : load_value;
            sub_d = SUB_ZERO;
        end else if (is_cw && is_ccw) begin
            conflict_d = 1'b1;
        end else if (is_cw) begin
            dir_d = 1'b1;
            if (sub_q == SUB_TOP) begin
                sub_d   = SUB_ZERO;
                inc_req = 1'b1;
            end else begin
                sub_d = sub_q + SUB_ONE;
            end
        end else if (is_ccw) begin
            dir_d = 1'b0;
            if (sub_q == SUB_BOT) begin
                sub_d   = SUB_ZERO;
                dec_req = 1'b1;
            end else begin
                sub_d = sub_q - SUB_ONE;
            end
        end

        // Bounds are checked before the +/-1, so no width overflow can occur.
        if (inc_req) begin
            if (pos_q < POS_MAX) begin
                pos_d = pos_q + POS_ONE;
            end else if (WRAP != 0) begin
                pos_d = '0;
            end
        end
        if (dec_req) begin
            if (pos_q != '0) begin
                pos_d = pos_q - POS_ONE;
            end else if (WRAP != 0) begin
                pos_d = POS_MAX;
            end
        end

        // A saturated step or a load of the current value is not a change.
        changed_d = (pos_d != pos_q);
    end

    assign position = pos_q;
    assign changed  = changed_q;
    assign dir      = dir_q;
    assign conflict = conflict_q;
    assign at_min   = (pos_q == '0);
    assign at_max   = (pos_q == POS_MAX);

endmodule

// File: tb/tb_rotary_position_counter.sv
// Purpose: directed check of rotary_position_counter, saturating and wrapping builds.
// Latency: inputs driven on falling edge, outputs sampled 1 time unit after rising edge.
// Backpressure: n/a.

module tb_rotary_position_counter;

    logic       tb_clock;
    logic       reset;
    logic       is_cw;
    logic       is_ccw;
    logic       load;
    logic [7:0] load_value;

    logic [7:0] pos_s, pos_w;
    logic       chg_s, chg_w;
    logic       dir_s, dir_w;
    logic       amin_s, amin_w;
    logic       amax_s, amax_w;
    logic       cnf_s, cnf_w;

    int n_vec  = 0;
    int n_miss = 0;

    rotary_position_counter #(
        .WIDTH(8), .STEPS_PER_DETENT(4), .MAX_VALUE(10), .WRAP(0)
    ) dut_sat (
        .clock(tb_clock), .reset(reset), .is_cw(is_cw), .is_ccw(is_ccw),
        .load(load), .load_value(load_value), .position(pos_s),
        .changed(chg_s), .dir(dir_s), .at_min(amin_s), .at_max(amax_s),
        .conflict(cnf_s)
    );

    rotary_position_counter #(
        .WIDTH(8), .STEPS_PER_DETENT(4), .MAX_VALUE(10), .WRAP(1)
    ) dut_wrap (
        .clock(tb_clock), .reset(reset), .is_cw(is_cw), .is_ccw(is_ccw),
        .load(load), .load_value(load_value), .position(pos_w),
        .changed(chg_w), .dir(dir_w), .at_min(amin_w), .at_max(amax_w),
        .conflict(cnf_w)
    );

    initial tb_clock = 1'b0;
    always #5 tb_clock = ~tb_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle of stimulus; outputs are settled on return.
    task automatic tick(input logic cw, input logic ccw, input logic ld, input logic [7:0] lv);
        @(negedge tb_clock);
        reset      = 1'b0;
        is_cw      = cw;
        is_ccw     = ccw;
        load       = ld;
        load_value = lv;
        @(posedge tb_clock);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        is_cw      = 1'b0;
        is_ccw     = 1'b0;
        load       = 1'b0;
        load_value = 8'd0;
        repeat (2) @(posedge tb_clock);
        #1;

        // Reset state
        check("rst_pos",   32'(pos_s),  0);
        check("rst_chg",   32'(chg_s),  0);
        check("rst_cnf",   32'(cnf_s),  0);
        check("rst_dir",   32'(dir_s),  0);
        check("rst_amin",  32'(amin_s), 1);
        check("rst_amax",  32'(amax_s), 0);
        check("rst_pos_w", 32'(pos_w),  0);

        // Detent count: three pulses are a partial detent
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0);
            check("part_pos", 32'(pos_s), 0);
            check("part_chg", 32'(chg_s), 0);
        end
        tick(1, 0, 0, 0);
        check("det_pos",  32'(pos_s),  1);
        check("det_chg",  32'(chg_s),  1);
        check("det_dir",  32'(dir_s),  1);
        check("det_amin", 32'(amin_s), 0);
        tick(0, 0, 0, 0);
        check("det_chg_drop", 32'(chg_s), 0);
        check("det_pos_hold", 32'(pos_s), 1);

        // Back-to-back pulses: none lost, changed on every 4th
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 0, 0);
            check("b2b_chg", 32'(chg_s), (i % 4 == 3) ? 1 : 0);
        end
        check("b2b_pos",   32'(pos_s), 3);
        check("b2b_pos_w", 32'(pos_w), 3);

        // Reversal mid-detent returns sub to zero with no change
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0);
            check("rev_cw_chg", 32'(chg_s), 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0);
            check("rev_ccw_chg", 32'(chg_s), 0);
            check("rev_ccw_pos", 32'(pos_s), 3);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0);
            check("rev_dn_part", 32'(pos_s), 3);
        end
        tick(0, 1, 0, 0);
        check("rev_dn_pos", 32'(pos_s), 2);
        check("rev_dn_chg", 32'(chg_s), 1);
        check("rev_dn_dir", 32'(dir_s), 0);

        // Limits: load clamps to MAX_VALUE
        tick(0, 0, 1, 8'd15);
        check("ld_clamp_pos",   32'(pos_s),  10);
        check("ld_clamp_amax",  32'(amax_s), 1);
        check("ld_clamp_chg",   32'(chg_s),  1);
        check("ld_clamp_pos_w", 32'(pos_w),  10);

        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
        check("sat_hi_pos",  32'(pos_s),  10);
        check("sat_hi_chg",  32'(chg_s),  0);
        check("sat_hi_amax", 32'(amax_s), 1);
        check("wrap_hi_pos", 32'(pos_w),  0);
        check("wrap_hi_chg", 32'(chg_w),  1);
        check("wrap_hi_min", 32'(amin_w), 1);

        tick(0, 0, 1, 8'd0);
        check("ld0_pos",     32'(pos_s), 0);
        check("ld0_chg",     32'(chg_s), 1);
        check("ld0_same_w",  32'(chg_w), 0);

        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
        check("sat_lo_pos",  32'(pos_s),  0);
        check("sat_lo_chg",  32'(chg_s),  0);
        check("sat_lo_amin", 32'(amin_s), 1);
        check("wrap_lo_pos", 32'(pos_w),  10);
        check("wrap_lo_chg", 32'(chg_w),  1);
        check("wrap_lo_max", 32'(amax_w), 1);

        // Wrap build: load 10, wrap up then back down
        tick(0, 0, 1, 8'd10);
        check("ld10_pos",   32'(pos_s), 10);
        check("ld10_chg_w", 32'(chg_w), 0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
        check("wrp_up_pos", 32'(pos_w), 0);
        check("wrp_up_chg", 32'(chg_w), 1);
        check("sat_up_pos", 32'(pos_s), 10);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
        check("wrp_dn_pos", 32'(pos_w), 10);
        check("wrp_dn_chg", 32'(chg_w), 1);
        check("sat_dn_pos", 32'(pos_s), 9);

        // Conflict mid-detent leaves sub, position and dir untouched
        tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        check("cnf_pulse",   32'(cnf_s), 1);
        check("cnf_pulse_w", 32'(cnf_w), 1);
        check("cnf_pos",     32'(pos_s), 9);
        check("cnf_dir",     32'(dir_s), 1);
        check("cnf_chg",     32'(chg_s), 0);
        tick(0, 0, 0, 0);
        check("cnf_drop", 32'(cnf_s), 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("cnf_sub_kept", 32'(pos_s), 9);
        tick(1, 0, 0, 0);
        check("cnf_after_pos",   32'(pos_s), 10);
        check("cnf_after_pos_w", 32'(pos_w), 0);

        // Load wins over a same-cycle step and clears sub
        tick(1, 0, 0, 0);
        tick(1, 0, 1, 8'd5);
        check("ldcw_pos",   32'(pos_s), 5);
        check("ldcw_pos_w", 32'(pos_w), 5);
        check("ldcw_chg",   32'(chg_s), 1);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0);
            check("ldcw_sub0", 32'(pos_s), 5);
        end
        tick(1, 0, 0, 0);
        check("ldcw_det", 32'(pos_s), 6);

        // Reset mid-detent discards the partial steps
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        @(negedge tb_clock);
        reset = 1'b1;
        is_cw = 1'b1;
        @(posedge tb_clock);
        #1;
        check("mrst_pos", 32'(pos_s), 0);
        check("mrst_chg", 32'(chg_s), 0);
        check("mrst_dir", 32'(dir_s), 0);
        check("mrst_cnf", 32'(cnf_s), 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0);
            check("mrst_part", 32'(pos_s), 0);
        end
        tick(1, 0, 0, 0);
        check("mrst_det_pos", 32'(pos_s), 1);
        check("mrst_det_chg", 32'(chg_s), 1);

        tick(0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
